// File: rtl/debug_bus_master.sv
// Debug-port bus master: halts the CPU, owns the memory bus for one write or a 1..256-word read burst, then releases both.
// Latency: single read with HALTED already high = REQ edge + 5 cycles to DONE; each extra burst word adds WAIT_STATES+2 cycles.
// Backpressure: none; REQ is taken only in IDLE and dropped otherwise, and ABORT cancels any bus-owning or halt-waiting phase.
module debug_bus_master #(
    parameter int WAIT_STATES  = 1,
    parameter int HALT_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        REQ_WR,
    input  logic [15:0] REQ_ADDR,
    input  logic [15:0] REQ_WDATA,
    input  logic [7:0]  REQ_LEN,
    input  logic        ABORT,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] RDATA,
    output logic        RDATA_VALID,
    output logic        HALT_REQ,
    input  logic        HALTED,
    output logic        DBG_BUS_EN,
    output logic [15:0] DBG_ADDR,
    output logic [15:0] DBG_DOUT,
    input  logic [15:0] DIN,
    output logic        DBG_RD,
    output logic        DBG_WR
);

    localparam int TW = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
    localparam int WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [TW-1:0] TLAST = TW'(HALT_TIMEOUT - 1);
    localparam logic [WW-1:0] WLAST = WW'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT_WAIT,
        S_SETUP,
        S_STROBE,
        S_RELEASE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          err_set;
    logic          strobe_last;
    logic          bus_own;

    logic [15:0]   addr;
    logic [15:0]   wdata;
    logic          is_wr;
    logic [7:0]    rem;
    logic [TW-1:0] tcnt;
    logic [WW-1:0] wcnt;
    logic          err;
    logic [15:0]   rdata;
    logic          rdata_vld;

    assign strobe_last = (wcnt == WLAST);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (REQ) state_nxt = S_HALT_WAIT;
            end
            S_HALT_WAIT: begin
                // abort beats a late HALTED so a cancelled request never touches the bus
                if (ABORT) begin
                    state_nxt = S_RELEASE;
                    err_set   = 1'b1;
                end else if (HALTED) begin
                    state_nxt = S_SETUP;
                end else if (tcnt == TLAST) begin
                    state_nxt = S_RELEASE;
                    err_set   = 1'b1;
                end
            end
            S_SETUP: begin
                if (ABORT) begin
                    state_nxt = S_RELEASE;
                    err_set   = 1'b1;
                end else begin
                    state_nxt = S_STROBE;
                end
            end
            S_STROBE: begin
                if (ABORT) begin
                    state_nxt = S_RELEASE;
                    err_set   = 1'b1;
                end else if (strobe_last) begin
                    state_nxt = (rem != 8'd0) ? S_SETUP : S_RELEASE;
                end
            end
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            addr      <= '0;
            wdata     <= '0;
            is_wr     <= 1'b0;
            rem       <= '0;
            tcnt      <= '0;
            wcnt      <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            rdata_vld <= 1'b0;
        end else begin
            rdata_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (REQ) begin
                        addr  <= REQ_ADDR;
                        wdata <= REQ_WDATA;
                        is_wr <= REQ_WR;
                        rem   <= REQ_WR ? 8'd0 : REQ_LEN;
                        err   <= 1'b0;
                        tcnt  <= '0;
                    end
                end
                S_HALT_WAIT: tcnt <= tcnt + 1'b1;
                S_SETUP:     wcnt <= '0;
                S_STROBE: begin
                    // an aborted word is neither captured nor reported
                    if (!ABORT) begin
                        wcnt <= wcnt + 1'b1;
                        if (strobe_last) begin
                            if (!is_wr) begin
                                rdata     <= DIN;
                                rdata_vld <= 1'b1;
                            end
                            if (rem != 8'd0) begin
                                addr <= addr + 16'd1;
                                rem  <= rem - 8'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
            if (err_set) err <= 1'b1;
        end
    end

    assign bus_own     = (state == S_SETUP) || (state == S_STROBE);
    assign BUSY        = (state != S_IDLE);
    assign DONE        = (state == S_RELEASE);
    assign HALT_REQ    = (state == S_HALT_WAIT) || bus_own;
    assign DBG_BUS_EN  = bus_own;
    assign DBG_ADDR    = bus_own ? addr : 16'h0000;
    assign DBG_DOUT    = bus_own ? wdata : 16'h0000;
    assign DBG_RD      = (state == S_STROBE) && !is_wr;
    assign DBG_WR      = (state == S_STROBE) && is_wr;
    assign ERR         = err;
    assign RDATA       = rdata;
    assign RDATA_VALID = rdata_vld;

endmodule

// File: tb/tb_debug_bus_master.sv
// Scoreboarded bench for debug_bus_master: directed operations push expected read words and DONE/ERR
// outcomes; a negedge monitor pops and compares them as the DUT presents them.
module tb_debug_bus_master;

    logic        CLK;
    logic        RESET;
    logic        REQ;
    logic        REQ_WR;
    logic [15:0] REQ_ADDR;
    logic [15:0] REQ_WDATA;
    logic [7:0]  REQ_LEN;
    logic        ABORT;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [15:0] RDATA;
    logic        RDATA_VALID;
    logic        HALT_REQ;
    logic        HALTED;
    logic        DBG_BUS_EN;
    logic [15:0] DBG_ADDR;
    logic [15:0] DBG_DOUT;
    logic [15:0] DIN;
    logic        DBG_RD;
    logic        DBG_WR;

    int checks   = 0;
    int failures = 0;
    int viol     = 0;
    int wr_cycles_total = 0;
    logic [15:0] last_wa = 16'h0;
    logic [15:0] last_wd = 16'h0;
    logic        prev_en = 1'b0;

    logic [15:0] exp_rd[$];
    bit          exp_err[$];

    debug_bus_master #(.WAIT_STATES(1), .HALT_TIMEOUT(255)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_WR(REQ_WR), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA), .REQ_LEN(REQ_LEN), .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE),
        .ERR(ERR), .RDATA(RDATA), .RDATA_VALID(RDATA_VALID), .HALT_REQ(HALT_REQ),
        .HALTED(HALTED), .DBG_BUS_EN(DBG_BUS_EN), .DBG_ADDR(DBG_ADDR), .DBG_DOUT(DBG_DOUT),
        .DIN(DIN), .DBG_RD(DBG_RD), .DBG_WR(DBG_WR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // memory image: 0x0100 holds 0xBEEF, every other word is its address XOR 0x5A5A
    function automatic logic [15:0] memval(input logic [15:0] a);
        return (a == 16'h0100) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction
    assign DIN = DBG_RD ? memval(DBG_ADDR) : 16'hDEAD;

    always @(posedge CLK) begin
        if (DBG_WR && DBG_BUS_EN) begin
            last_wa <= DBG_ADDR;
            last_wd <= DBG_DOUT;
            wr_cycles_total <= wr_cycles_total + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    always @(negedge CLK) begin
        if (RDATA_VALID) begin
            if (exp_rd.size() == 0) check("unexpected_rdata_valid", 32'd1, 32'd0);
            else check("rdata", {16'h0, RDATA}, {16'h0, exp_rd.pop_front()});
        end
        if (DONE) begin
            if (exp_err.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else check("done_err", {31'h0, ERR}, {31'h0, exp_err.pop_front()});
        end
        if ((DBG_RD || DBG_WR) && !DBG_BUS_EN) viol++;
        if (DBG_RD && DBG_WR) viol++;
        if ((DBG_RD || DBG_WR) && (DBG_BUS_EN != prev_en)) viol++;
        prev_en = DBG_BUS_EN;
    end

    task automatic do_req(input logic wr, input logic [15:0] a, input logic [15:0] d, input logic [7:0] len);
        @(posedge CLK); #1;
        REQ = 1'b1; REQ_WR = wr; REQ_ADDR = a; REQ_WDATA = d; REQ_LEN = len;
        @(posedge CLK); #1;
        REQ = 1'b0;
    endtask

    // counts cycles from the accepting edge up to and including the DONE cycle
    task automatic wait_done(input int budget, input logic [15:0] ea, input logic [15:0] ed,
                             input bit chk_a, input bit chk_d,
                             output int n, output int rdc, output int wrc, output int busc,
                             output int adbad, output int haltc, output logic vld_at_done);
        n = 0; rdc = 0; wrc = 0; busc = 0; adbad = 0; haltc = 0; vld_at_done = 1'b0;
        forever begin
            @(negedge CLK);
            n++;
            if (DBG_RD) rdc++;
            if (DBG_WR) wrc++;
            if (HALT_REQ) haltc++;
            if (DBG_BUS_EN) begin
                busc++;
                if ((chk_a && DBG_ADDR != ea) || (chk_d && DBG_DOUT != ed)) adbad++;
            end
            if (DONE) begin
                vld_at_done = RDATA_VALID;
                break;
            end
            if (n >= budget) begin
                check("done_timeout", 32'd1, 32'd0);
                n = -1;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n, rdc, wrc, busc, adbad, haltc;
        logic vld;

        RESET = 1'b0; REQ = 1'b0; REQ_WR = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
        REQ_LEN = '0; ABORT = 1'b0; HALTED = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_ctrl", {24'h0, BUSY, DONE, ERR, RDATA_VALID, HALT_REQ, DBG_BUS_EN, DBG_RD, DBG_WR}, 32'h0);
        check("reset_data", {RDATA, DBG_ADDR}, 32'h0);
        @(posedge CLK); #1 RESET = 1'b1;

        // 1: single read of 0x0100
        exp_rd.push_back(16'hBEEF); exp_err.push_back(1'b0);
        do_req(1'b0, 16'h0100, 16'h0000, 8'd0);
        wait_done(50, 16'h0100, 16'h0, 1'b1, 1'b0, n, rdc, wrc, busc, adbad, haltc, vld);
        check("t1_latency", n, 5);
        check("t1_rd_cycles", rdc, 2);
        check("t1_wr_cycles", wrc, 0);
        check("t1_addr_stable", adbad, 0);
        check("t1_valid_with_done", {31'h0, vld}, 32'd1);
        repeat (2) @(posedge CLK);

        // 2: single write 0x1234 -> 0x2000
        exp_err.push_back(1'b0);
        do_req(1'b1, 16'h2000, 16'h1234, 8'd7);
        wait_done(50, 16'h2000, 16'h1234, 1'b1, 1'b1, n, rdc, wrc, busc, adbad, haltc, vld);
        check("t2_latency", n, 5);
        check("t2_wr_cycles", wrc, 2);
        check("t2_rd_cycles", rdc, 0);
        check("t2_bus_cycles", busc, 3);
        check("t2_addr_data_stable", adbad, 0);
        check("t2_mem_write", {last_wa, last_wd}, 32'h2000_1234);
        repeat (2) @(posedge CLK);

        // 3: 4-word read wrapping past 0xFFFF, with a REQ pulse mid-burst that must be ignored
        exp_rd.push_back(16'hA5A4); exp_rd.push_back(16'hA5A5);
        exp_rd.push_back(16'h5A5A); exp_rd.push_back(16'h5A5B);
        exp_err.push_back(1'b0);
        do_req(1'b0, 16'hFFFE, 16'h0000, 8'd3);
        fork
            wait_done(80, 16'h0, 16'h0, 1'b0, 1'b0, n, rdc, wrc, busc, adbad, haltc, vld);
            begin
                repeat (2) @(posedge CLK); #1;
                REQ = 1'b1; REQ_WR = 1'b1; REQ_ADDR = 16'h3000; REQ_WDATA = 16'h7777;
                @(posedge CLK); #1 REQ = 1'b0;
            end
        join
        check("t3_latency", n, 14);
        check("t3_rd_cycles", rdc, 8);
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        check("t3_no_second_op_busy", {31'h0, BUSY}, 32'd0);
        check("t3_no_second_op_write", wr_cycles_total, 2);

        // 4: halt never granted
        HALTED = 1'b0;
        exp_err.push_back(1'b1);
        do_req(1'b0, 16'h0200, 16'h0000, 8'd0);
        wait_done(400, 16'h0, 16'h0, 1'b0, 1'b0, n, rdc, wrc, busc, adbad, haltc, vld);
        check("t4_latency", n, 256);
        check("t4_bus_en_cycles", busc, 0);
        check("t4_halt_req_cycles", haltc, 255);
        HALTED = 1'b1;
        repeat (2) @(posedge CLK);

        // 5: abort in the second strobe cycle of word 2 of a 4-word read at 0x0300
        exp_rd.push_back(16'h595A); exp_err.push_back(1'b1);
        do_req(1'b0, 16'h0300, 16'h0000, 8'd3);
        repeat (6) @(posedge CLK);
        #1 ABORT = 1'b1;
        @(negedge CLK);
        check("t5_strobe_before_abort", {31'h0, DBG_RD}, 32'd1);
        @(posedge CLK); #1 ABORT = 1'b0;
        @(negedge CLK);
        check("t5_strobe_dropped", {31'h0, DBG_RD}, 32'd0);
        check("t5_done", {31'h0, DONE}, 32'd1);
        @(negedge CLK);
        check("t5_busy_after", {31'h0, BUSY}, 32'd0);
        repeat (2) @(posedge CLK);

        // 6: REQ while busy, then reset during the strobe
        do_req(1'b0, 16'h0400, 16'h0000, 8'd3);
        @(posedge CLK); #1 REQ = 1'b1; REQ_WR = 1'b1; REQ_ADDR = 16'h5000;
        @(posedge CLK); #1 REQ = 1'b0;
        @(negedge CLK);
        check("t6_strobe_active", {31'h0, DBG_RD}, 32'd1);
        @(posedge CLK); #1 RESET = 1'b0;
        @(negedge CLK);
        @(posedge CLK); #1 RESET = 1'b0;
        check("t6_reset_ctrl", {24'h0, BUSY, DONE, ERR, RDATA_VALID, HALT_REQ, DBG_BUS_EN, DBG_RD, DBG_WR}, 32'h0);
        check("t6_reset_data", {RDATA, DBG_ADDR}, 32'h0);
        check("t6_reset_dout", {16'h0, DBG_DOUT}, 32'h0);
        #1 RESET = 1'b1;
        repeat (8) @(posedge CLK);
        @(negedge CLK);
        check("t6_idle_after_reset", {31'h0, BUSY}, 32'd0);

        check("queue_rdata_empty", exp_rd.size(), 0);
        check("queue_done_empty", exp_err.size(), 0);
        check("strobe_bus_en_protocol", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
